// File: rtl/ps2_teclado_rx_pkg.sv
// rtl/ps2_teclado_rx_pkg.sv - shared constants, FSM states and frame check for the PS/2 receiver
package ps2_teclado_rx_pkg;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  // fr holds {stop, parity, d7..d0}; odd parity over data+parity and a high stop bit
  function automatic logic frame_ok(input logic [9:0] fr);
    return (^fr[8:0]) & fr[9];
  endfunction

endpackage

// File: rtl/ps2_filtro.sv
// rtl/ps2_filtro.sv - PS/2 line synchronizer, ps2_clk debouncer and falling-edge strobe
module ps2_filtro #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_f,
  output logic fall,
  output logic dat_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [CW-1:0] cnt;
  logic          clk_s;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // two-flop synchronizers; both lines idle high on an open-collector bus
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // accept a new ps2_clk level only after it has differed from clk_f for FILTER_LEN cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_f <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_f) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clk_f <= clk_s;
        fall  <= clk_f & ~clk_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_teclado_rx.sv
// rtl/ps2_teclado_rx.sv - PS/2 keyboard receiver with prefix stripping and sticky new_data
module ps2_teclado_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ack,
  output logic [7:0] data,
  output logic       new_data,
  output logic       released,
  output logic       extended,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  import ps2_teclado_rx_pkg::*;

  localparam logic [17:0] TO_LAST  = 18'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  ps2_state_t  state;
  logic [9:0]  shreg;
  logic [3:0]  bitcnt;
  logic [17:0] tocnt;
  logic        ext_pend;
  logic        brk_pend;
  logic        fall;
  logic        dat_s;
  logic        clk_f_unused;
  logic [7:0]  code;

  assign code = shreg[7:0];
  assign busy = (state != IDLE);

  ps2_filtro #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_f    (clk_f_unused),
    .fall     (fall),
    .dat_s    (dat_s)
  );

  // frame FSM: start detection, bit shifting, timeout, then one cycle of frame evaluation
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      tocnt     <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      data      <= 8'h00;
      new_data  <= 1'b0;
      released  <= 1'b0;
      extended  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (ack) begin
        new_data <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        IDLE: begin
          tocnt <= '0;
          // a high data bit on the first fall is a false start and is silently dropped
          if (fall && !dat_s) begin
            state  <= RECV;
            bitcnt <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shreg  <= {dat_s, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tocnt  <= '0;
            if (bitcnt == LAST_BIT) state <= CHECK;
          end else if (tocnt == TO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (tocnt != '1) begin
            tocnt <= tocnt + 18'd1;
          end
        end
        CHECK: begin
          state <= IDLE;
          tocnt <= '0;
          if (!frame_ok(shreg)) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else if (code == PS2_PFX_EXT) begin
            ext_pend <= 1'b1;
          end else if (code == PS2_PFX_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            data     <= code;
            released <= brk_pend;
            extended <= ext_pend;
            new_data <= 1'b1;
            // a coincident ack consumes the old code, so the new one is not an overrun
            overrun  <= !ack && (overrun || new_data);
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// tb/tb_ps2_teclado_rx.sv - self-checking bench for ps2_teclado_rx
module tb_ps2_teclado_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       new_data, released, extended, overrun, frame_err, busy;

  ps2_teclado_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ack       (ack),
    .data      (data),
    .new_data  (new_data),
    .released  (released),
    .extended  (extended),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int err_pulses = 0;
  int err_cycles = 0;
  logic err_prev = 1'b0;
  int last_lat = -1;

  logic [7:0] m_data = 8'h00;
  bit m_new = 0, m_rel = 0, m_ext = 0, m_ovr = 0, m_ep = 0, m_bp = 0;
  int m_err = 0;

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (frame_err && !err_prev) err_pulses++;
    err_prev = frame_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit bad);
    return {1'b1, (~^code) ^ bad, code, 1'b0};
  endfunction

  task automatic model_ack();
    m_new = 0;
    m_ovr = 0;
  endtask

  task automatic model_frame(input logic [7:0] code, input bit bad);
    if (bad) begin
      m_err++;
      m_ep = 0;
      m_bp = 0;
    end else if (code == 8'hE0) begin
      m_ep = 1;
    end else if (code == 8'hF0) begin
      m_bp = 1;
    end else begin
      m_ovr  = m_ovr | m_new;
      m_new  = 1;
      m_data = code;
      m_rel  = m_bp;
      m_ext  = m_ep;
      m_ep   = 0;
      m_bp   = 0;
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_new = 0; m_rel = 0; m_ext = 0; m_ovr = 0; m_ep = 0; m_bp = 0;
  endtask

  // bits lo..hi of a frame; ack_chk pulses ack in the cycle the stop bit is evaluated
  task automatic send_bits(input logic [10:0] fr, input int lo, input int hi, input bit ack_chk);
    last_lat = -1;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(negedge clk);
        if (i == 10 && ack_chk) ack = (c == FILTER_LEN + 3);
        if (i == 10 && last_lat < 0 && new_data) last_lat = c;
      end
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_code(input logic [7:0] code, input bit bad, input bit ack_chk);
    send_bits(mk_frame(code, bad), 0, 10, ack_chk);
    if (ack_chk) model_ack();
    model_frame(code, bad);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    model_ack();
  endtask

  task automatic check_model(input string tag);
    chk({tag, " data"}, data, m_data);
    chk({tag, " new_data"}, new_data, m_new);
    chk({tag, " released"}, released, m_rel);
    chk({tag, " extended"}, extended, m_ext);
    chk({tag, " overrun"}, overrun, m_ovr);
    chk({tag, " err_count"}, err_pulses, m_err);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " data"}, data, 0);
    chk({tag, " new_data"}, new_data, 0);
    chk({tag, " released"}, released, 0);
    chk({tag, " extended"}, extended, 0);
    chk({tag, " overrun"}, overrun, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    bit         ack_first;
    logic [7:0] e_data;
    bit         e_new, e_rel, e_ext, e_ovr;
    int         e_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int e0;
    logic [7:0] c;
    bit b, a, ac;
    int r;

    tbl[0]  = '{8'h1C, 0, 0, 8'h1C, 1, 0, 0, 0, 0};
    tbl[1]  = '{8'hF0, 0, 1, 8'h1C, 0, 0, 0, 0, 0};
    tbl[2]  = '{8'h1C, 0, 0, 8'h1C, 1, 1, 0, 0, 0};
    tbl[3]  = '{8'hE0, 0, 1, 8'h1C, 0, 1, 0, 0, 0};
    tbl[4]  = '{8'h75, 0, 0, 8'h75, 1, 0, 1, 0, 0};
    tbl[5]  = '{8'h1C, 1, 1, 8'h75, 0, 0, 1, 0, 1};
    tbl[6]  = '{8'h32, 0, 0, 8'h32, 1, 0, 0, 0, 0};
    tbl[7]  = '{8'h24, 0, 0, 8'h24, 1, 0, 0, 1, 0};
    tbl[8]  = '{8'hE0, 0, 1, 8'h24, 0, 0, 0, 0, 0};
    tbl[9]  = '{8'hE0, 0, 0, 8'h24, 0, 0, 0, 0, 0};
    tbl[10] = '{8'hF0, 0, 0, 8'h24, 0, 0, 0, 0, 0};
    tbl[11] = '{8'hF0, 0, 0, 8'h24, 0, 0, 0, 0, 0};
    tbl[12] = '{8'h6B, 0, 0, 8'h6B, 1, 1, 1, 0, 0};
    tbl[13] = '{8'hE0, 0, 0, 8'h6B, 1, 1, 1, 0, 0};
    tbl[14] = '{8'hF0, 1, 0, 8'h6B, 1, 1, 1, 0, 1};
    tbl[15] = '{8'h5A, 0, 0, 8'h5A, 1, 0, 0, 1, 0};

    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].ack_first) pulse_ack();
      e0 = err_pulses;
      send_code(tbl[i].code, tbl[i].bad, 1'b0);
      chk($sformatf("tbl%0d data", i), data, tbl[i].e_data);
      chk($sformatf("tbl%0d new_data", i), new_data, tbl[i].e_new);
      chk($sformatf("tbl%0d released", i), released, tbl[i].e_rel);
      chk($sformatf("tbl%0d extended", i), extended, tbl[i].e_ext);
      chk($sformatf("tbl%0d overrun", i), overrun, tbl[i].e_ovr);
      chk($sformatf("tbl%0d frame_err", i), err_pulses - e0, tbl[i].e_err);
      if (i == 0) chk("latency", last_lat, FILTER_LEN + 4);
    end

    // stall mid-frame until the timeout fires
    pulse_ack();
    e0 = err_pulses;
    send_bits(mk_frame(8'h1C, 0), 0, 4, 1'b0);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    chk("timeout err", err_pulses - e0, 1);
    chk("timeout busy", busy, 0);
    m_err++;
    send_code(8'h1C, 0, 0);
    check_model("after_timeout");

    // overrun, ack clear, ack coinciding with the publishing cycle
    send_code(8'h32, 0, 0);
    chk("ovr data", data, 8'h32);
    chk("ovr overrun", overrun, 1);
    pulse_ack();
    chk("ack new_data", new_data, 0);
    chk("ack overrun", overrun, 0);
    chk("ack data hold", data, 8'h32);
    send_code(8'h55, 0, 0);
    send_code(8'h24, 0, 1);
    chk("ackchk new_data", new_data, 1);
    chk("ackchk overrun", overrun, 0);
    chk("ackchk data", data, 8'h24);
    check_model("ackchk");

    // reset in the middle of a frame; the tail becomes a false start then a timeout
    send_bits(mk_frame(8'h1C, 0), 0, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("midreset");
    model_reset();
    send_bits(mk_frame(8'h1C, 0), 5, 10, 1'b0);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    m_err++;
    check_model("midreset_tail");
    send_code(8'h3A, 0, 0);
    check_model("midreset_next");

    // ps2_clk glitches one cycle shorter than the filter must not start a frame
    e0 = err_pulses;
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (4) begin
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    chk("glitch busy", busy, 0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("glitch err", err_pulses - e0, 0);
    send_code(8'h1C, 0, 0);
    check_model("after_glitch");

    // randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) c = 8'hE0;
      else if (r < 4) c = 8'hF0;
      else c = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 9) < 3);
      ac = ($urandom_range(0, 9) == 0);
      if (a) pulse_ack();
      send_code(c, b, ac);
      check_model($sformatf("rnd%0d", n));
    end

    chk("err_width", err_cycles, err_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
